// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: shared access codes, state encoding and size helpers
package data_mem_ctrl_pkg;
  localparam int LOAD_TYPE_NUM_WIDTH = 3;
  localparam logic [2:0] LOAD_LB = 3'b000;
  localparam logic [2:0] LOAD_LH = 3'b001;
  localparam logic [2:0] LOAD_LW = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [1:0] STORE_BYTE = 2'b00;
  localparam logic [1:0] STORE_HALF = 2'b01;
  localparam logic [1:0] STORE_WORD = 2'b10;
  localparam logic [1:0] IO_ADDR_HI_DEFAULT = 2'b11;
  typedef enum logic [1:0] {MEM_IDLE, MEM_LOAD, MEM_STORE} mem_state_e;
  function automatic logic [2:0] load_bytes(input logic [2:0] t);
    return t[1] ? 3'd4 : t[0] ? 3'd2 : 3'd1;
  endfunction
  function automatic logic [2:0] store_bytes(input logic [1:0] t);
    return t[1] ? 3'd4 : t[0] ? 3'd2 : 3'd1;
  endfunction
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: requester, result broadcast and byte-serial RAM bus signals
interface data_mem_ctrl_if #(parameter int ROB_SIZE_WIDTH = 5);
  logic rob_valid;
  logic [1:0] rob_store_type;
  logic [31:0] rob_addr;
  logic [31:0] rob_value;
  logic lsb_valid;
  logic [2:0] lsb_load_type;
  logic [31:0] lsb_addr;
  logic [ROB_SIZE_WIDTH:0] lsb_dependency;
  logic io_buffer_full;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic [31:0] mem_a;
  logic mem_wr;
  logic mem_busy;
  logic mem_valid;
  logic [ROB_SIZE_WIDTH:0] mem_dependency;
  logic [31:0] mem_value;
  modport master(
    output rob_valid, rob_store_type, rob_addr, rob_value,
    output lsb_valid, lsb_load_type, lsb_addr, lsb_dependency,
    output io_buffer_full, mem_din,
    input mem_dout, mem_a, mem_wr, mem_busy, mem_valid, mem_dependency, mem_value
  );
  modport slave(
    input rob_valid, rob_store_type, rob_addr, rob_value,
    input lsb_valid, lsb_load_type, lsb_addr, lsb_dependency,
    input io_buffer_full, mem_din,
    output mem_dout, mem_a, mem_wr, mem_busy, mem_valid, mem_dependency, mem_value
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-serial executor for committed stores and speculative loads
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ROB_SIZE_WIDTH = 5,
  parameter logic [1:0] IO_ADDR_HI = IO_ADDR_HI_DEFAULT
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic flush_in,
  data_mem_ctrl_if.slave bus
);
  mem_state_e state;
  logic [2:0] cnt, n, ld_type;
  logic [31:0] addr, value, data;
  logic [ROB_SIZE_WIDTH:0] tag;
  logic pend_v;
  logic [2:0] pend_type;
  logic [31:0] pend_addr;
  logic [ROB_SIZE_WIDTH:0] pend_tag;
  logic [31:0] cur_addr, nxt_data, ld_addr;
  logic [2:0] ld_src_type;
  logic [ROB_SIZE_WIDTH:0] ld_tag;
  logic [1:0] idx;
  logic stall, start_ld;

  function automatic logic [31:0] extend(input logic [2:0] t, input logic [31:0] v);
    return t == LOAD_LW ? v :
           t == LOAD_LH ? {{16{v[15]}}, v[15:0]} :
           t == LOAD_LHU ? {16'b0, v[15:0]} :
           t == LOAD_LB ? {{24{v[7]}}, v[7:0]} : {24'b0, v[7:0]};
  endfunction

  assign bus.mem_busy = state != MEM_IDLE || pend_v || bus.rob_valid || bus.lsb_valid;

  // byte addressing, read-data assembly, IO stall and load launch selection
  always_comb begin
    cur_addr = addr + {29'b0, cnt};
    idx = cnt[1:0] - 2'd2;
    nxt_data = data;
    nxt_data[{idx, 3'b000} +: 8] = bus.mem_din;
    stall = cur_addr[17:16] == IO_ADDR_HI && bus.io_buffer_full;
    ld_addr = state == MEM_STORE ? pend_addr : bus.lsb_addr;
    ld_src_type = state == MEM_STORE ? pend_type : bus.lsb_load_type;
    ld_tag = state == MEM_STORE ? pend_tag : bus.lsb_dependency;
    start_ld = !flush_in && (state == MEM_IDLE ? !bus.rob_valid && bus.lsb_valid :
                             state == MEM_STORE && cnt == n && pend_v);
  end

  // access sequencer: one RAM byte per edge, loads launch straight after a store
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= MEM_IDLE;
      cnt <= '0;
      n <= '0;
      ld_type <= '0;
      addr <= '0;
      value <= '0;
      data <= '0;
      tag <= '0;
      pend_v <= 1'b0;
      pend_type <= '0;
      pend_addr <= '0;
      pend_tag <= '0;
      bus.mem_dout <= '0;
      bus.mem_a <= '0;
      bus.mem_wr <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_dependency <= '1;
      bus.mem_value <= '0;
    end else if (rdy_in) begin
      bus.mem_valid <= 1'b0;
      if (flush_in) pend_v <= 1'b0;
      case (state)
        MEM_IDLE: if (bus.rob_valid) begin
          state <= MEM_STORE;
          bus.mem_wr <= 1'b0;
          cnt <= '0;
          addr <= bus.rob_addr;
          value <= bus.rob_value;
          n <= store_bytes(bus.rob_store_type);
          pend_v <= bus.lsb_valid && !flush_in;
          pend_type <= bus.lsb_load_type;
          pend_addr <= bus.lsb_addr;
          pend_tag <= bus.lsb_dependency;
        end
        MEM_LOAD: if (flush_in) begin
          state <= MEM_IDLE;
          bus.mem_wr <= 1'b0;
        end else begin
          cnt <= cnt + 3'd1;
          if (cnt < n) bus.mem_a <= cur_addr;
          if (cnt >= 3'd2) data <= nxt_data;
          if (cnt == n + 3'd1) begin
            bus.mem_valid <= 1'b1;
            bus.mem_dependency <= tag;
            bus.mem_value <= extend(ld_type, nxt_data);
            state <= MEM_IDLE;
          end
        end
        MEM_STORE: if (cnt == n) begin
          bus.mem_wr <= 1'b0;
          state <= MEM_IDLE;
        end else if (stall) begin
          bus.mem_wr <= 1'b0;
        end else begin
          bus.mem_a <= cur_addr;
          bus.mem_dout <= value[{cnt[1:0], 3'b000} +: 8];
          bus.mem_wr <= 1'b1;
          cnt <= cnt + 3'd1;
        end
        default: state <= MEM_IDLE;
      endcase
      if (start_ld) begin
        state <= MEM_LOAD;
        bus.mem_a <= ld_addr;
        bus.mem_wr <= 1'b0;
        cnt <= 3'd1;
        addr <= ld_addr;
        ld_type <= ld_src_type;
        n <= load_bytes(ld_src_type);
        tag <= ld_tag;
        pend_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed checks of loads, stores, IO stall, flush and reset
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush_in;
  logic pre_we;
  logic [9:0] pre_a;
  logic [7:0] pre_d;
  logic [7:0] ram [0:1023];
  int checks = 0;
  int fails = 0;

  data_mem_ctrl_if #(.ROB_SIZE_WIDTH(5)) bus();

  data_mem_ctrl #(.ROB_SIZE_WIDTH(5), .IO_ADDR_HI(2'b11)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .flush_in(flush_in),
    .bus(bus)
  );

  always #5 clk_in = ~clk_in;

  // RAM with one-cycle registered read plus a preload port
  always @(posedge clk_in) begin
    if (bus.mem_wr) ram[bus.mem_a[9:0]] <= bus.mem_dout;
    else if (pre_we) ram[pre_a] <= pre_d;
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a = a;
    pre_d = d;
    tick;
    pre_we = 1'b0;
  endtask

  task automatic issue_load(input logic [2:0] t, input logic [31:0] a, input logic [5:0] tg);
    bus.lsb_valid = 1'b1;
    bus.lsb_load_type = t;
    bus.lsb_addr = a;
    bus.lsb_dependency = tg;
    tick;
    bus.lsb_valid = 1'b0;
  endtask

  task automatic issue_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] v);
    bus.rob_valid = 1'b1;
    bus.rob_store_type = t;
    bus.rob_addr = a;
    bus.rob_value = v;
    tick;
    bus.rob_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic got);
    got = bus.mem_valid;
    for (int i = 0; i < 12 && !got; i++) begin
      tick;
      got = bus.mem_valid;
    end
  endtask

  task automatic test_reset;
    rst_in = 1'b1;
    tick;
    tick;
    rst_in = 1'b0;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h0 || bus.mem_dout !== 8'h0) begin
      fails++;
      $display("FAIL reset_bus got wr=%b a=%h dout=%h exp 0/0/0", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.mem_dependency !== 6'h3f || bus.mem_value !== 32'h0) begin
      fails++;
      $display("FAIL reset_result got v=%b dep=%h val=%h exp 0/3f/0", bus.mem_valid, bus.mem_dependency, bus.mem_value);
    end
    checks++;
    if (bus.mem_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_busy got %b exp 0", bus.mem_busy);
    end
  endtask

  task automatic test_lw;
    issue_load(LOAD_LW, 32'h100, 6'd9);
    checks++;
    if (bus.mem_a !== 32'h100) begin
      fails++;
      $display("FAIL lw_addr0 got %h exp 00000100", bus.mem_a);
    end
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i <= 3) begin
        checks++;
        if (bus.mem_a !== 32'h100 + i) begin
          fails++;
          $display("FAIL lw_addr%0d got %h exp %h", i, bus.mem_a, 32'h100 + i);
        end
      end
      checks++;
      if (bus.mem_valid !== (i == 5)) begin
        fails++;
        $display("FAIL lw_valid_edge%0d got %b exp %b", i, bus.mem_valid, i == 5);
      end
    end
    checks++;
    if (bus.mem_value !== 32'h44332211 || bus.mem_dependency !== 6'd9) begin
      fails++;
      $display("FAIL lw_result got %h tag %0d exp 44332211 tag 9", bus.mem_value, bus.mem_dependency);
    end
    tick;
    checks++;
    if (bus.mem_valid !== 1'b0) begin
      fails++;
      $display("FAIL lw_valid_drop got %b exp 0", bus.mem_valid);
    end
  endtask

  task automatic test_extend;
    logic got;
    logic [2:0] types [3] = '{LOAD_LB, LOAD_LBU, LOAD_LHU};
    logic [31:0] addrs [3] = '{32'h10, 32'h10, 32'h20};
    logic [31:0] exps [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00008001};
    for (int i = 0; i < 3; i++) begin
      issue_load(types[i], addrs[i], 6'(i + 1));
      wait_valid(got);
      checks++;
      if (!got || bus.mem_value !== exps[i]) begin
        fails++;
        $display("FAIL extend_%0d got valid=%b val=%h exp %h", i, got, bus.mem_value, exps[i]);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] sw = 32'hDEADBEEF;
    bus.lsb_valid = 1'b1;
    bus.lsb_load_type = LOAD_LH;
    bus.lsb_addr = 32'h200;
    bus.lsb_dependency = 6'd5;
    issue_store(STORE_WORD, 32'h200, sw);
    bus.lsb_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      checks++;
      if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h200 + k || bus.mem_dout !== sw[8*k +: 8] || bus.mem_busy !== 1'b1) begin
        fails++;
        $display("FAIL b2b_write%0d got wr=%b a=%h d=%h busy=%b exp 1/%h/%h/1", k, bus.mem_wr, bus.mem_a, bus.mem_dout, bus.mem_busy, 32'h200 + k, sw[8*k +: 8]);
      end
    end
    tick;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'h200 || bus.mem_busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_load_start got wr=%b a=%h busy=%b exp 0/00000200/1", bus.mem_wr, bus.mem_a, bus.mem_busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (bus.mem_busy !== 1'b1 || bus.mem_valid !== 1'b0) begin
        fails++;
        $display("FAIL b2b_busy%0d got busy=%b valid=%b exp 1/0", i, bus.mem_busy, bus.mem_valid);
      end
    end
    tick;
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_value !== 32'hFFFFBEEF || bus.mem_dependency !== 6'd5) begin
      fails++;
      $display("FAIL b2b_result got v=%b val=%h tag=%0d exp 1/ffffbeef/5", bus.mem_valid, bus.mem_value, bus.mem_dependency);
    end
    tick;
  endtask

  task automatic test_io_stall;
    bus.io_buffer_full = 1'b1;
    issue_store(STORE_BYTE, 32'h30000, 32'h41);
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (bus.mem_wr !== 1'b0) begin
        fails++;
        $display("FAIL io_stall%0d got wr=%b exp 0", i, bus.mem_wr);
      end
    end
    bus.io_buffer_full = 1'b0;
    tick;
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h30000 || bus.mem_dout !== 8'h41) begin
      fails++;
      $display("FAIL io_write got wr=%b a=%h d=%h exp 1/00030000/41", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    tick;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.mem_busy !== 1'b0) begin
      fails++;
      $display("FAIL io_done got wr=%b busy=%b exp 0/0", bus.mem_wr, bus.mem_busy);
    end
  endtask

  task automatic test_flush;
    logic seen = 1'b0;
    logic got;
    issue_load(LOAD_LW, 32'h100, 6'd7);
    flush_in = 1'b1;
    tick;
    flush_in = 1'b0;
    checks++;
    if (bus.mem_busy !== 1'b0 || bus.mem_wr !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle got busy=%b wr=%b exp 0/0", bus.mem_busy, bus.mem_wr);
    end
    for (int i = 0; i < 8; i++) begin
      seen = seen | bus.mem_valid;
      tick;
    end
    issue_load(LOAD_LB, 32'h10, 6'd8);
    tick;
    flush_in = 1'b1;
    tick;
    flush_in = 1'b0;
    seen = seen | bus.mem_valid;
    tick;
    seen = seen | bus.mem_valid;
    checks++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL flush_suppress got valid seen=%b exp 0", seen);
    end
    issue_store(STORE_HALF, 32'h40, 32'h0000ABCD);
    tick;
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h40 || bus.mem_dout !== 8'hCD) begin
      fails++;
      $display("FAIL flush_sh0 got wr=%b a=%h d=%h exp 1/00000040/cd", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    tick;
    checks++;
    if (bus.mem_wr !== 1'b1 || bus.mem_a !== 32'h41 || bus.mem_dout !== 8'hAB) begin
      fails++;
      $display("FAIL flush_sh1 got wr=%b a=%h d=%h exp 1/00000041/ab", bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    tick;
    issue_load(LOAD_LHU, 32'h40, 6'd3);
    wait_valid(got);
    checks++;
    if (!got || bus.mem_value !== 32'h0000ABCD) begin
      fails++;
      $display("FAIL flush_sh_readback got valid=%b val=%h exp 0000abcd", got, bus.mem_value);
    end
    tick;
  endtask

  task automatic test_reset_mid_store;
    issue_store(STORE_WORD, 32'h300, 32'h11223344);
    tick;
    tick;
    rst_in = 1'b1;
    tick;
    rst_in = 1'b0;
    checks++;
    if (bus.mem_wr !== 1'b0 || bus.mem_dependency !== 6'h3f || bus.mem_busy !== 1'b0 || bus.mem_a !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid got wr=%b dep=%h busy=%b a=%h exp 0/3f/0/0", bus.mem_wr, bus.mem_dependency, bus.mem_busy, bus.mem_a);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    pre_we = 1'b0;
    pre_a = '0;
    pre_d = '0;
    bus.rob_valid = 1'b0;
    bus.rob_store_type = '0;
    bus.rob_addr = '0;
    bus.rob_value = '0;
    bus.lsb_valid = 1'b0;
    bus.lsb_load_type = '0;
    bus.lsb_addr = '0;
    bus.lsb_dependency = '0;
    bus.io_buffer_full = 1'b0;
    test_reset;
    preload(10'h100, 8'h11);
    preload(10'h101, 8'h22);
    preload(10'h102, 8'h33);
    preload(10'h103, 8'h44);
    preload(10'h010, 8'h80);
    preload(10'h020, 8'h01);
    preload(10'h021, 8'h80);
    test_lw;
    test_extend;
    test_back_to_back;
    test_io_stall;
    test_flush;
    test_reset_mid_store;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-side responder for the out-of-order core's data traffic. Sits between the ROB/LSB and the byte-serial RAM/IO bus.
- Executes committed stores from the ROB and speculative loads from the LSB, one byte per cycle.
- Returns load results on the shared mem_valid/mem_dependency/mem_value broadcast.
- Drives mem_busy, which both requesters sample before issuing.

Parameters:
ROB_SIZE_WIDTH, 5, ROB index width; dependency tags are ROB_SIZE_WIDTH+1 bits.
IO_ADDR_HI, 2'b11, value of address bits [17:16] that marks the IO window.

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  global enable; low freezes all state and outputs
flush_in  input  1  ROB misprediction flush
rob_valid  input  1  one-cycle committed-store request
rob_store_type  input  2  00 byte, 01 half, 10 word
rob_addr  input  32  store address
rob_value  input  32  store data, little-endian
lsb_valid  input  1  one-cycle load request
lsb_load_type  input  3  funct3 encoding: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
lsb_addr  input  32  load address
lsb_dependency  input  ROB_SIZE_WIDTH+1  ROB tag of the load
io_buffer_full  input  1  IO write buffer full
mem_din  input  8  RAM read data
mem_dout  output  8  RAM write data (registered)
mem_a  output  32  RAM address (registered)
mem_wr  output  1  1 = write (registered)
mem_busy  output  1  combinational: state!=IDLE or pending load or rob_valid or lsb_valid
mem_valid  output  1  one-cycle load-result strobe
mem_dependency  output  ROB_SIZE_WIDTH+1  tag of the result
mem_value  output  32  extended load result

Behaviour:
- Reset values: mem_dout 0, mem_a 0, mem_wr 0, mem_valid 0, mem_dependency all-ones, mem_value 0, state IDLE, pending empty, byte counter 0.
- States:
  - IDLE, LOAD, STORE.
  - N = bytes per access: 1, 2 or 4.
  - Byte counter is 3 bits.
- Acceptance:
  - Requests are sampled only in IDLE.
  - rob_valid has priority over lsb_valid.
  - If both are high in the same cycle, the store is accepted and the load is latched into a one-entry pending slot.
  - Requests arriving outside IDLE are protocol violations; the requesters guarantee they never occur because mem_busy gates issue.
- LOAD, with E0 = accept edge:
  - At E0..E(N-1): mem_a <= addr+k, mem_wr <= 0.
  - The byte addressed at Ek is sampled from mem_din at E(k+2).
  - At E(N+1): mem_value <= sign- or zero-extended assembled value, mem_dependency <= tag, mem_valid <= 1, state <= IDLE.
  - mem_valid drops at the next edge.
  - Latency: LB request cycle to mem_valid high = 3 edges; LW = 6 edges.
- STORE:
  - At E0: enter STORE with mem_wr <= 0.
  - At E1..EN: mem_a <= addr+k, mem_dout <= value[8k+7:8k], mem_wr <= 1.
  - At E(N+1): mem_wr <= 0, state <= IDLE.
- IO stall:
  - Applies when the target address has [17:16]==IO_ADDR_HI and io_buffer_full is high at an edge.
  - Under stall, no byte is written: mem_wr <= 0 and the counter holds.
  - Writing resumes on the first edge where io_buffer_full is low.
- Pending load: at the store's final edge, a pending load starts immediately; that edge is its E0.
- Flush:
  - flush_in high at an edge aborts an in-flight LOAD; its mem_valid is suppressed even on the completion edge.
  - The pending slot is cleared, lsb_valid in the same cycle is ignored, and state goes to IDLE with mem_wr <= 0.
  - An in-flight or same-cycle STORE is unaffected, because it is already committed.
- Address wrap: addr+k is 32-bit modular.
- Reset mid-operation: all state returns to reset values at once; partially written stores are abandoned.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

Decomposition:
- const_param.v gains:
  - LOAD_TYPE_NUM_WIDTH (3) and the five load codes.
  - STORE_BYTE/HALF/WORD codes, shared with the ROB.
  - MEM_STATE codes.
  - IO_ADDR_HI.
- No sub-module; extension is a local function.

Test Plan:
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x44 -> mem_a 0x100..0x103 on consecutive cycles; mem_valid high exactly 6 edges after request; mem_value 0x44332211; mem_dependency = tag.
- LB of byte 0x80 -> mem_value 0xFFFFFF80; LBU of the same byte -> 0x00000080; LHU of 0x8001 -> 0x00008001.
- SW 0xDEADBEEF to 0x200 with rob_valid and lsb_valid (LH 0x200, tag 5) in the same cycle -> writes EF,BE,AD,DE to 0x200..0x203; then the load starts with no idle cycle; mem_value 0xFFFFBEEF, tag 5; mem_busy high throughout.
- SB 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles; one write follows with mem_a 0x30000, mem_dout 0x41.
- LW in flight, flush_in pulsed at its second address edge -> no mem_valid; state IDLE next edge; a following SH completes normally.
- rst_in asserted mid-SW -> next edge mem_wr 0, mem_dependency all-ones, mem_busy 0 once inputs are low.
